// File: rtl/acq_seq.sv
// Acquisition sequencer: a trigger rise runs a burst of avg_n periods of t cycles.
// Each period fires the sensor, then gates ADC strobes into the averager for a d-cycle window.
module acq_seq #(
    parameter int delay      = 100,
    parameter int t          = 256,
    parameter int t_log2     = 8,
    parameter int d          = 64,
    parameter int avg_n      = 64,
    parameter int avg_n_log2 = 6,
    parameter int cnt_w      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             abort,
    input  logic             adc_rdy,
    output logic             fire,
    output logic             sample_en,
    output logic             sample_valid,
    output logic             avg_clr,
    output logic             busy,
    output logic             done,
    output logic [cnt_w-1:0] n_samples
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [t_log2-1:0]     CYC_LAST   = t_log2'(t - 1);
    localparam logic [avg_n_log2-1:0] PULSE_LAST = avg_n_log2'(avg_n - 1);
    // One extra bit so delay+d == t is representable.
    localparam logic [t_log2:0]       WIN_LO     = (t_log2 + 1)'(delay);
    localparam logic [t_log2:0]       WIN_HI     = (t_log2 + 1)'(delay + d);

    state_t                  state, state_nxt;
    logic [t_log2-1:0]       cyc, cyc_nxt;
    logic [avg_n_log2-1:0]   pulse, pulse_nxt;
    logic                    trigger_q;
    logic                    rise;
    logic                    start;

    assign rise = trigger & ~trigger_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cyc       <= '0;
            pulse     <= '0;
            trigger_q <= 1'b0;
            n_samples <= '0;
        end else begin
            state     <= state_nxt;
            cyc       <= cyc_nxt;
            pulse     <= pulse_nxt;
            trigger_q <= trigger;
            if (start)
                n_samples <= '0;
            else if (sample_valid && n_samples != '1)
                n_samples <= n_samples + cnt_w'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc;
        pulse_nxt = pulse;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = RUN;
                    cyc_nxt   = '0;
                    pulse_nxt = '0;
                    start     = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    cyc_nxt   = '0;
                    pulse_nxt = '0;
                end else if (cyc == CYC_LAST) begin
                    cyc_nxt = '0;
                    if (pulse == PULSE_LAST) begin
                        state_nxt = DONE;
                        pulse_nxt = '0;
                    end else begin
                        pulse_nxt = pulse + avg_n_log2'(1);
                    end
                end else begin
                    cyc_nxt = cyc + t_log2'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cyc_nxt   = '0;
                pulse_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                cyc_nxt   = '0;
                pulse_nxt = '0;
            end
        endcase
    end

    // Everything except sample_valid is decoded from registers only.
    assign busy         = (state == RUN);
    assign done         = (state == DONE);
    assign fire         = busy && (cyc == '0);
    assign avg_clr      = fire && (pulse == '0);
    assign sample_en    = busy && ({1'b0, cyc} >= WIN_LO) && ({1'b0, cyc} < WIN_HI);
    assign sample_valid = adc_rdy & sample_en;

endmodule
